stage_responder: RTL and testbench
==================================

// Module: stage_responder
// PURPOSE
//  Executing end of the four-stage step controller's enable interface. Consumes en1..en4
//  (one-hot stage strobes issued per step in auto or manual mode) and performs the work of each stage:
//  load A, load B, execute ALU op, write back result. Reports per-stage completion (done),
//  busy and protocol errors back to the controller and the LED/display logic.
// PARAMETERS
//  WIDTH         8  operand/result width in bits
//  STAGE_CYCLES  4  cycles from accepted enable to completion of a stage; legal range >=1
// PORTS
//  clk           in   1      single clock, all state on posedge
//  rst           in   1      asynchronous, active-high reset
//  en1..en4      in   1 ea   stage enables from the step controller, level signals
//  a_in          in   WIDTH  operand A, captured in stage 1
//  b_in          in   WIDTH  operand B, captured in stage 2
//  op            in   2      00 add, 01 sub, 10 and, 11 xor; sampled in stage 3
//  busy          out  1      stage in progress
//  done          out  1      one-cycle pulse, stage completed
//  stage_id      out  2      index (0..3) of stage in progress / last completed
//  result        out  WIDTH  written-back result
//  result_valid  out  1      result holds a completed op
//  carry, zero   out  1 ea   flags of written-back result
//  err           out  1      sticky protocol error
// BEHAVIOUR
//  - Reset (async, any time, incl. mid-stage): all outputs 0, A/B/res regs 0, exp_stage=0, state IDLE.
//  - Enables registered once (en_q); a start = en_k high at edge t and low at edge t-1.
//  - States: IDLE, RUN, ERROR. IDLE->RUN on a start of stage k==exp_stage with no other en high;
//    cnt<=STAGE_CYCLES-1, stage_id<=k, busy=1 from edge t.
//  - RUN: cnt decrements each cycle; at edge where cnt==0 (edge t+STAGE_CYCLES): perform stage
//    action, done=1 for exactly that cycle, busy=0, exp_stage<=exp_stage+1 (3 wraps to 0), ->IDLE.
//  - Actions: k0 A<=a_in; k1 B<=b_in; k2 {carry_r,res}<=op result (add: A+B carry-out;
//    sub: A+~B+1 carry-out, i.e. 1 = no borrow; and/xor: carry 0); k3 result<=res,
//    carry<=carry_r, zero<=(res==0), result_valid<=1. result_valid cleared on next k0 action.
//  - Abort: active en_k drops while RUN -> IDLE at next edge, no action, no done, exp_stage unchanged;
//    same stage may be restarted.
//  - Protocol error -> ERROR, err=1, busy=0: start of stage != exp_stage; >1 enable high on any edge;
//    any start while RUN. ERROR is sticky; only rst leaves it. Outputs other than err/busy hold.
//  - Enable held high after done: no retrigger (edge-based). Enable level during IDLE ignored.
//  - Operand inputs sampled only at the action edge; changes during RUN are legal.
// STRUCTURE
//  - stage_pkg: state typedef (IDLE/RUN/ERROR), op_t enum (OP_ADD/OP_SUB/OP_AND/OP_XOR),
//    stage index constants ST_LOAD_A..ST_WB.
//  - Sub-module stage_alu (combinational, WIDTH param): A, B, op -> res, carry. Top holds FSM,
//    counter, edge detect and registers.
// TESTING
//  - Reset: assert rst mid-RUN -> busy/done/err/result/result_valid all 0 same cycle, exp_stage 0.
//  - Full sequence, STAGE_CYCLES=4: A=8'h3C,B=8'h0F,op=00, en1..en4 in order -> 4 done pulses,
//    each 4 cycles after its start; result=8'h4B, carry=0, zero=0, result_valid=1.
//  - Sub: A=8'h05,B=8'h05,op=01 -> result=8'h00, zero=1, carry=1; A=8'h01,B=8'h02 -> 8'hFF, carry=0.
//  - Overflow: A=8'hFF,B=8'h01,op=00 -> result=8'h00, carry=1, zero=1.
//  - Abort: drop en2 after 2 cycles -> no done, A/B unchanged; re-raise en2 -> completes normally.
//  - Errors: en3 start when exp_stage=1 -> err=1 sticky; en1&en2 high together -> err=1;
//    STAGE_CYCLES=1: done exactly 1 cycle after start.

Source files
------------

// File: rtl/stage_pkg.sv
// Shared types for the stage responder: FSM states, ALU opcodes, stage indices.
package stage_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    ERROR = 2'd2
  } state_t;

  typedef enum logic [1:0] {
    OP_ADD = 2'd0,
    OP_SUB = 2'd1,
    OP_AND = 2'd2,
    OP_XOR = 2'd3
  } op_t;

  localparam logic [1:0] ST_LOAD_A = 2'd0;
  localparam logic [1:0] ST_LOAD_B = 2'd1;
  localparam logic [1:0] ST_EXEC   = 2'd2;
  localparam logic [1:0] ST_WB     = 2'd3;

  // Index of the lowest set bit; callers guarantee at most one bit is set.
  function automatic logic [1:0] onehot_idx(input logic [3:0] v);
    logic [1:0] idx;
    idx = 2'd0;
    if (v[0])      idx = 2'd0;
    else if (v[1]) idx = 2'd1;
    else if (v[2]) idx = 2'd2;
    else if (v[3]) idx = 2'd3;
    return idx;
  endfunction

endpackage

// File: rtl/stage_alu.sv
// Combinational ALU for the execute stage; zero latency.
// Subtract reports carry = 1 when no borrow occurs (A >= B).
module stage_alu
  import stage_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  op_t              op,
  output logic [WIDTH-1:0] res,
  output logic             carry
);

  logic [WIDTH:0] ext;

  always_comb begin
    ext   = '0;
    res   = '0;
    carry = 1'b0;
    case (op)
      OP_ADD: begin
        ext   = {1'b0, a} + {1'b0, b};
        res   = ext[WIDTH-1:0];
        carry = ext[WIDTH];
      end
      OP_SUB: begin
        ext   = {1'b0, a} + {1'b0, ~b} + {{WIDTH{1'b0}}, 1'b1};
        res   = ext[WIDTH-1:0];
        carry = ext[WIDTH];
      end
      OP_AND: res = a & b;
      OP_XOR: res = a ^ b;
      default: res = '0;
    endcase
  end

endmodule

// File: rtl/stage_responder.sv
// Executes one stage per accepted enable edge: load A, load B, ALU op, write back.
// Completion (done) comes STAGE_CYCLES edges after the start edge; protocol errors lock up until reset.
module stage_responder
  import stage_pkg::*;
#(
  parameter int WIDTH        = 8,
  parameter int STAGE_CYCLES = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en1,
  input  logic             en2,
  input  logic             en3,
  input  logic             en4,
  input  logic [WIDTH-1:0] a_in,
  input  logic [WIDTH-1:0] b_in,
  input  logic [1:0]       op,
  output logic             busy,
  output logic             done,
  output logic [1:0]       stage_id,
  output logic [WIDTH-1:0] result,
  output logic             result_valid,
  output logic             carry,
  output logic             zero,
  output logic             err
);

  localparam int CW = (STAGE_CYCLES > 1) ? $clog2(STAGE_CYCLES) : 1;
  localparam logic [CW-1:0] CNT_INIT = CW'(STAGE_CYCLES - 1);

  state_t           state;
  logic [CW-1:0]    cnt;
  logic [1:0]       exp_stage;
  logic [3:0]       en;
  logic [3:0]       en_q;
  logic [3:0]       starts;
  logic             multi;
  logic             start_any;
  logic [1:0]       start_idx;
  logic             proto_err;
  logic [WIDTH-1:0] a_r;
  logic [WIDTH-1:0] b_r;
  logic [WIDTH-1:0] res_r;
  logic             carry_r;
  logic [WIDTH-1:0] alu_res;
  logic             alu_carry;

  assign en        = {en4, en3, en2, en1};
  assign starts    = en & ~en_q;
  assign multi     = ($countones(en) > 1);
  assign start_any = |starts;
  assign start_idx = onehot_idx(starts);

  // Any new start while a stage runs is illegal, even when the old enable drops on the same edge.
  assign proto_err = (state != ERROR) &&
                     (multi || (start_any && ((state == RUN) || (start_idx != exp_stage))));

  stage_alu #(
    .WIDTH(WIDTH)
  ) u_alu (
    .a    (a_r),
    .b    (b_r),
    .op   (op_t'(op)),
    .res  (alu_res),
    .carry(alu_carry)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= IDLE;
      cnt          <= '0;
      exp_stage    <= 2'd0;
      en_q         <= 4'd0;
      a_r          <= '0;
      b_r          <= '0;
      res_r        <= '0;
      carry_r      <= 1'b0;
      busy         <= 1'b0;
      done         <= 1'b0;
      stage_id     <= 2'd0;
      result       <= '0;
      result_valid <= 1'b0;
      carry        <= 1'b0;
      zero         <= 1'b0;
      err          <= 1'b0;
    end else begin
      en_q <= en;
      done <= 1'b0;
      if (proto_err) begin
        state <= ERROR;
        err   <= 1'b1;
        busy  <= 1'b0;
      end else begin
        case (state)
          IDLE: begin
            if (start_any) begin
              state    <= RUN;
              cnt      <= CNT_INIT;
              stage_id <= start_idx;
              busy     <= 1'b1;
            end
          end
          RUN: begin
            if (!en[stage_id]) begin
              state <= IDLE;
              busy  <= 1'b0;
            end else if (cnt == '0) begin
              case (stage_id)
                ST_LOAD_A: begin
                  a_r          <= a_in;
                  result_valid <= 1'b0;
                end
                ST_LOAD_B: b_r <= b_in;
                ST_EXEC: begin
                  res_r   <= alu_res;
                  carry_r <= alu_carry;
                end
                ST_WB: begin
                  result       <= res_r;
                  carry        <= carry_r;
                  zero         <= (res_r == '0);
                  result_valid <= 1'b1;
                end
                default: ;
              endcase
              done      <= 1'b1;
              busy      <= 1'b0;
              exp_stage <= exp_stage + 2'd1;
              state     <= IDLE;
            end else begin
              cnt <= cnt - 1'b1;
            end
          end
          ERROR: ;
          default: state <= ERROR;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_stage_responder.sv
// Bench for stage_responder: cycle-stamped behavioural model plus directed literal checks.
module tb_stage_responder;

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] en_a;
  logic [3:0] en_b;
  logic [7:0] a_in;
  logic [7:0] b_in;
  logic [1:0] op;

  logic       busy_a, done_a, rv_a, carry_a, zero_a, err_a;
  logic [1:0] sid_a;
  logic [7:0] result_a;
  logic       busy_b, done_b, rv_b, carry_b, zero_b, err_b;
  logic [1:0] sid_b;
  logic [7:0] result_b;

  int errors = 0;
  int checks = 0;
  int cyc    = 0;
  bit cmp_on = 1'b0;

  always #5 clk = ~clk;

  stage_responder #(.WIDTH(8), .STAGE_CYCLES(4)) u_dut (
    .clk(clk), .rst(rst),
    .en1(en_a[0]), .en2(en_a[1]), .en3(en_a[2]), .en4(en_a[3]),
    .a_in(a_in), .b_in(b_in), .op(op),
    .busy(busy_a), .done(done_a), .stage_id(sid_a), .result(result_a),
    .result_valid(rv_a), .carry(carry_a), .zero(zero_a), .err(err_a)
  );

  stage_responder #(.WIDTH(8), .STAGE_CYCLES(1)) u_dut1 (
    .clk(clk), .rst(rst),
    .en1(en_b[0]), .en2(en_b[1]), .en3(en_b[2]), .en4(en_b[3]),
    .a_in(a_in), .b_in(b_in), .op(op),
    .busy(busy_b), .done(done_b), .stage_id(sid_b), .result(result_b),
    .result_valid(rv_b), .carry(carry_b), .zero(zero_b), .err(err_b)
  );

  typedef struct {
    bit         err;
    bit         run;
    int         k;
    int         t0;
    int         expst;
    logic [7:0] ra;
    logic [7:0] rb;
    logic [7:0] rres;
    bit         rc;
    logic [7:0] result;
    bit         carry;
    bit         zero;
    bit         rv;
    bit         done;
    bit         busy;
    int         sid;
  } mdl_t;

  mdl_t ma, mb;
  logic [3:0] pa, pb;

  function automatic mdl_t m_reset();
    mdl_t m;
    m = '{default: 0};
    return m;
  endfunction

  // Model: a stage started at edge t0 finishes at edge t0+sc unless its enable drops first.
  function automatic mdl_t m_step(mdl_t mi, logic [3:0] en, logic [3:0] prev, int now, int sc,
                                  logic [7:0] a, logic [7:0] b, logic [1:0] o);
    mdl_t       m;
    logic [3:0] st;
    int         n;
    int         k;
    int         sum;
    m    = mi;
    st   = en & ~prev;
    n    = $countones(en);
    m.done = 1'b0;
    if (m.err) return m;
    if (n > 1 || (st != 4'd0 && m.run)) begin
      m.err = 1'b1; m.busy = 1'b0; m.run = 1'b0;
      return m;
    end
    if (m.run) begin
      if (!en[m.k]) begin
        m.run = 1'b0; m.busy = 1'b0;
      end else if (now - m.t0 == sc) begin
        case (m.k)
          0: begin m.ra = a; m.rv = 1'b0; end
          1: m.rb = b;
          2: begin
            case (o)
              2'd0: begin sum = int'(m.ra) + int'(m.rb); m.rres = sum[7:0]; m.rc = (sum > 255); end
              2'd1: begin m.rres = m.ra - m.rb; m.rc = (m.ra >= m.rb); end
              2'd2: begin m.rres = m.ra & m.rb; m.rc = 1'b0; end
              default: begin m.rres = m.ra ^ m.rb; m.rc = 1'b0; end
            endcase
          end
          default: begin
            m.result = m.rres; m.carry = m.rc; m.zero = (m.rres == 8'd0); m.rv = 1'b1;
          end
        endcase
        m.done = 1'b1; m.busy = 1'b0; m.run = 1'b0;
        m.expst = (m.expst + 1) % 4;
      end
    end else if (st != 4'd0) begin
      k = st[0] ? 0 : st[1] ? 1 : st[2] ? 2 : 3;
      if (k == m.expst) begin
        m.run = 1'b1; m.k = k; m.t0 = now; m.sid = k; m.busy = 1'b1;
      end else begin
        m.err = 1'b1; m.busy = 1'b0;
      end
    end
    return m;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  always @(posedge clk) begin
    if (rst) begin
      ma = m_reset(); mb = m_reset(); pa = 4'd0; pb = 4'd0;
    end else begin
      cyc++;
      ma = m_step(ma, en_a, pa, cyc, 4, a_in, b_in, op); pa = en_a;
      mb = m_step(mb, en_b, pb, cyc, 1, a_in, b_in, op); pb = en_b;
    end
    #1;
    if (cmp_on) begin
      chk("a.busy", busy_a, ma.busy);       chk("a.done", done_a, ma.done);
      chk("a.stage_id", sid_a, ma.sid);     chk("a.result", result_a, ma.result);
      chk("a.result_valid", rv_a, ma.rv);   chk("a.carry", carry_a, ma.carry);
      chk("a.zero", zero_a, ma.zero);       chk("a.err", err_a, ma.err);
      chk("b.busy", busy_b, mb.busy);       chk("b.done", done_b, mb.done);
      chk("b.stage_id", sid_b, mb.sid);     chk("b.result", result_b, mb.result);
      chk("b.result_valid", rv_b, mb.rv);   chk("b.carry", carry_b, mb.carry);
      chk("b.zero", zero_b, mb.zero);       chk("b.err", err_b, mb.err);
    end
  end

  // Raise one enable, measure edges from start to done (bounded), then drop it.
  task automatic stage(input bit on_b, input int k, input int lat_exp);
    int n;
    bit seen;
    @(negedge clk);
    if (on_b) en_b = 4'b0001 << k; else en_a = 4'b0001 << k;
    n = 0; seen = 1'b0;
    while (!seen && n < 30) begin
      @(posedge clk); #2;
      n++;
      seen = on_b ? done_b : done_a;
    end
    chk($sformatf("latency_%s_stage%0d", on_b ? "b" : "a", k), n - 1, lat_exp);
    @(negedge clk);
    en_a = 4'd0; en_b = 4'd0;
    @(negedge clk);
  endtask

  task automatic run_op(input logic [7:0] a, input logic [7:0] b, input logic [1:0] o,
                        input logic [7:0] r, input bit c, input bit z);
    a_in = a; b_in = b; op = o;
    for (int k = 0; k < 4; k++) stage(1'b0, k, 4);
    chk($sformatf("result_%h_%h_%0d", a, b, o), result_a, r);
    chk("carry_lit", carry_a, c);
    chk("zero_lit", zero_a, z);
    chk("result_valid_lit", rv_a, 1'b1);
  endtask

  task automatic pulse_reset();
    @(negedge clk); rst = 1'b1; en_a = 4'd0; en_b = 4'd0;
    @(negedge clk); rst = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int nd;
    rst = 1'b1; en_a = 4'd0; en_b = 4'd0; a_in = 8'd0; b_in = 8'd0; op = 2'd0;
    repeat (2) @(posedge clk);
    #1;
    chk("reset_busy", busy_a, 1'b0);
    chk("reset_err", err_a, 1'b0);
    chk("reset_result", result_a, 8'd0);
    @(negedge clk); rst = 1'b0; cmp_on = 1'b1;

    run_op(8'h3C, 8'h0F, 2'd0, 8'h4B, 1'b0, 1'b0);
    run_op(8'h05, 8'h05, 2'd1, 8'h00, 1'b1, 1'b1);
    run_op(8'h01, 8'h02, 2'd1, 8'hFF, 1'b0, 1'b0);
    run_op(8'hFF, 8'h01, 2'd0, 8'h00, 1'b1, 1'b1);
    run_op(8'hF0, 8'h3C, 2'd2, 8'h30, 1'b0, 1'b0);
    run_op(8'hAA, 8'hAA, 2'd3, 8'h00, 1'b0, 1'b1);

    // Abort of stage 1 after two cycles, then a clean restart with a new operand.
    a_in = 8'h11; op = 2'd0;
    stage(1'b0, 0, 4);
    chk("rv_cleared_by_load_a", rv_a, 1'b0);
    b_in = 8'h22;
    @(negedge clk); en_a = 4'b0010;
    repeat (2) @(negedge clk);
    en_a = 4'd0;
    nd = 0;
    repeat (8) begin @(posedge clk); #2; if (done_a) nd++; end
    chk("abort_no_done", nd, 0);
    chk("abort_busy", busy_a, 1'b0);
    b_in = 8'h33;
    stage(1'b0, 1, 4);
    stage(1'b0, 2, 4);
    stage(1'b0, 3, 4);
    chk("abort_restart_result", result_a, 8'h44);

    // Asynchronous reset in the middle of a running stage.
    @(negedge clk); en_a = 4'b0001;
    repeat (2) @(negedge clk);
    chk("midrun_busy", busy_a, 1'b1);
    rst = 1'b1;
    #1;
    chk("arst_busy", busy_a, 1'b0);
    chk("arst_done", done_a, 1'b0);
    chk("arst_err", err_a, 1'b0);
    chk("arst_result", result_a, 8'd0);
    chk("arst_result_valid", rv_a, 1'b0);
    @(negedge clk); rst = 1'b0; en_a = 4'd0;
    stage(1'b0, 0, 4);
    chk("post_reset_no_err", err_a, 1'b0);

    // Out-of-order start is sticky even when a legal start follows.
    @(negedge clk); en_a = 4'b0100;
    @(negedge clk);
    chk("order_err", err_a, 1'b1);
    en_a = 4'd0;
    @(negedge clk); en_a = 4'b0010;
    repeat (6) @(negedge clk);
    chk("order_err_sticky", err_a, 1'b1);
    chk("order_err_busy", busy_a, 1'b0);
    pulse_reset();

    // Two enables high at once.
    @(negedge clk); en_a = 4'b0011;
    @(negedge clk);
    chk("multi_en_err", err_a, 1'b1);
    pulse_reset();

    // Single-cycle stages on the second instance.
    a_in = 8'h07; b_in = 8'h09; op = 2'd0;
    for (int k = 0; k < 4; k++) stage(1'b1, k, 1);
    chk("sc1_result", result_b, 8'h10);
    chk("sc1_err", err_b, 1'b0);

    repeat (2) @(negedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
